id_type_i_pipe: RTL and testbench

Registered, parametrised decoder for RISC-V OP-IMM (and, for XLEN=64, OP-IMM-32) instructions in the ID stage. It reads rs1 through the register-file read port, builds op1/op2, ALU opcode and writeback controls, and flags malformed encodings as illegal. Results are held in a two-entry skid buffer with valid/ready handshakes on both sides, so ID sustains one instruction per cycle under EX back-pressure. Sits between the IF/ID register and the ID/EX handoff.

---
 rtl/id_type_i_pipe.sv | 184 ++++++++++++++++++
 tb/tb_id_type_i_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_type_i_pipe.sv
// rtl/id_type_i_pipe.sv - OP-IMM / OP-IMM-32 decoder with two-entry output skid buffer
// Optional macro ID_FWD_EN: bypass writeback data into op1 at accept time.
module id_type_i_pipe #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        inst_i,
    output logic [RADDR_W-1:0] reg1_raddr_o,
    output logic               reg1_re_o,
    input  logic [XLEN-1:0]    reg1_rdata_i,
    input  logic               fwd_we_i,
    input  logic [RADDR_W-1:0] fwd_waddr_i,
    input  logic [XLEN-1:0]    fwd_wdata_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    op1_o,
    output logic [XLEN-1:0]    op2_o,
    output logic [3:0]         alu_op_o,
    output logic               word_op_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               illegal_o
);

    localparam bit IS64 = (XLEN == 64);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLT  = 4'd1;
    localparam logic [3:0] ALU_SLTU = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;

    typedef struct packed {
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic [3:0]         alu_op;
        logic               word_op;
        logic               reg_we;
        logic [RADDR_W-1:0] reg_waddr;
        logic               illegal;
    } entry_t;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    imm_sext;
    logic [XLEN-1:0]    shamt_w;
    logic [XLEN-1:0]    shamt_x;
    logic               hi_zero;
    logic               hi_sra;
    logic               w_zero;
    logic               w_sra;
    logic [XLEN-1:0]    rs1_val;

    logic               legal;
    logic [3:0]         alu;
    logic [XLEN-1:0]    op2;
    logic               word;
    entry_t             dec;

    assign opcode   = inst_i[6:0];
    assign funct3   = inst_i[14:12];
    assign rs1      = RADDR_W'(inst_i[19:15]);
    assign rd       = RADDR_W'(inst_i[11:7]);
    assign imm_sext = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign shamt_w  = XLEN'(inst_i[24:20]);
    assign shamt_x  = IS64 ? XLEN'(inst_i[25:20]) : shamt_w;
    // Native shifts on RV64 free up inst[25] as the sixth shamt bit.
    assign hi_zero  = IS64 ? (inst_i[31:26] == 6'b000000) : (inst_i[31:25] == 7'b0000000);
    assign hi_sra   = IS64 ? (inst_i[31:26] == 6'b010000) : (inst_i[31:25] == 7'b0100000);
    assign w_zero   = (inst_i[31:25] == 7'b0000000);
    assign w_sra    = (inst_i[31:25] == 7'b0100000);

`ifdef ID_FWD_EN
    assign rs1_val = (fwd_we_i && (fwd_waddr_i == rs1) && (rs1 != '0)) ? fwd_wdata_i : reg1_rdata_i;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_we_i, fwd_waddr_i, fwd_wdata_i};
    assign rs1_val    = reg1_rdata_i;
`endif

    always_comb begin
        legal = 1'b0;
        alu   = ALU_ADD;
        op2   = '0;
        word  = 1'b0;
        if (opcode == 7'b0010011) begin
            op2 = imm_sext;
            case (funct3)
                3'b000: begin legal = 1'b1; alu = ALU_ADD;  end
                3'b010: begin legal = 1'b1; alu = ALU_SLT;  end
                3'b011: begin legal = 1'b1; alu = ALU_SLTU; end
                3'b100: begin legal = 1'b1; alu = ALU_XOR;  end
                3'b110: begin legal = 1'b1; alu = ALU_OR;   end
                3'b111: begin legal = 1'b1; alu = ALU_AND;  end
                3'b001: begin legal = hi_zero; alu = ALU_SLL; op2 = shamt_x; end
                default: begin
                    legal = hi_zero | hi_sra;
                    alu   = hi_sra ? ALU_SRA : ALU_SRL;
                    op2   = shamt_x;
                end
            endcase
        end else if (IS64 && (opcode == 7'b0011011)) begin
            word = 1'b1;
            case (funct3)
                3'b000: begin legal = 1'b1; alu = ALU_ADD; op2 = imm_sext; end
                3'b001: begin legal = w_zero; alu = ALU_SLL; op2 = shamt_w; end
                3'b101: begin
                    legal = w_zero | w_sra;
                    alu   = w_sra ? ALU_SRA : ALU_SRL;
                    op2   = shamt_w;
                end
                default: legal = 1'b0;
            endcase
        end

        dec.op1       = legal ? rs1_val : '0;
        dec.op2       = legal ? op2 : '0;
        dec.alu_op    = legal ? alu : ALU_ADD;
        dec.word_op   = legal & word;
        dec.reg_we    = legal;
        dec.reg_waddr = legal ? rd : '0;
        dec.illegal   = ~legal;
    end

    assign reg1_re_o    = legal;
    assign reg1_raddr_o = legal ? rs1 : '0;

    entry_t out_q;
    entry_t skid_q;
    logic   out_valid_q;
    logic   skid_valid_q;
    logic   accept;

    assign in_ready_o = ~skid_valid_q & ~rst;
    assign accept     = in_valid_i & in_ready_o & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            // A full SKID deasserts in_ready, so it never competes with a new accept here.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid_o = out_valid_q;
    assign op1_o       = out_q.op1;
    assign op2_o       = out_q.op2;
    assign alu_op_o    = out_q.alu_op;
    assign word_op_o   = out_q.word_op;
    assign reg_we_o    = out_q.reg_we;
    assign reg_waddr_o = out_q.reg_waddr;
    assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_id_type_i_pipe.sv
// tb/tb_id_type_i_pipe.sv - self-checking bench for id_type_i_pipe at XLEN=32 and XLEN=64
module tb_id_type_i_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst;
    logic        out_ready;
    logic        fwd_we;
    logic [4:0]  fwd_waddr;
    logic [63:0] fwd_wdata;
    logic [63:0] regs [32];

    logic        in_ready32, re32, out_valid32, word32, we32, ill32;
    logic [4:0]  raddr32, waddr32;
    logic [31:0] rdata32, op1_32, op2_32;
    logic [3:0]  alu32;

    logic        in_ready64, re64, out_valid64, word64, we64, ill64;
    logic [4:0]  raddr64, waddr64;
    logic [63:0] rdata64, op1_64, op2_64;
    logic [3:0]  alu64;

    int checks;
    int failures;

    assign rdata32 = regs[raddr32][31:0];
    assign rdata64 = regs[raddr64];

    id_type_i_pipe #(.XLEN(32), .RADDR_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready32),
        .inst_i(inst), .reg1_raddr_o(raddr32), .reg1_re_o(re32), .reg1_rdata_i(rdata32),
        .fwd_we_i(fwd_we), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata[31:0]),
        .out_valid_o(out_valid32), .out_ready_i(out_ready), .op1_o(op1_32), .op2_o(op2_32),
        .alu_op_o(alu32), .word_op_o(word32), .reg_we_o(we32), .reg_waddr_o(waddr32),
        .illegal_o(ill32)
    );

    id_type_i_pipe #(.XLEN(64), .RADDR_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready64),
        .inst_i(inst), .reg1_raddr_o(raddr64), .reg1_re_o(re64), .reg1_rdata_i(rdata64),
        .fwd_we_i(fwd_we), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
        .out_valid_o(out_valid64), .out_ready_i(out_ready), .op1_o(op1_64), .op2_o(op2_64),
        .alu_op_o(alu64), .word_op_o(word64), .reg_we_o(we64), .reg_waddr_o(waddr64),
        .illegal_o(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [3:0]  alu;
        logic        word;
        logic        we;
        logic [4:0]  waddr;
        logic        ill;
        logic [4:0]  raddr;
    } ent_t;

    ent_t q32[$];
    ent_t q64[$];

    // Reference decode straight from the ISA tables: legality, op2 source and ALU code.
    function automatic ent_t model(input int xlen, input logic [31:0] ins);
        ent_t        e;
        logic [63:0] mask, imm, src, op2;
        logic [3:0]  alu;
        logic        ok, word;
        logic [6:0]  opc, f7;
        logic [5:0]  f6;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        f6   = ins[31:26];
        rs1  = ins[19:15];
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        imm  = 64'($signed(ins[31:20]));
        ok   = 1'b0;
        alu  = 4'd0;
        op2  = 64'd0;
        word = 1'b0;
        if (opc == 7'h13) begin
            case (f3)
                3'd0: begin ok = 1'b1; alu = 4'd0; op2 = imm; end
                3'd2: begin ok = 1'b1; alu = 4'd1; op2 = imm; end
                3'd3: begin ok = 1'b1; alu = 4'd2; op2 = imm; end
                3'd4: begin ok = 1'b1; alu = 4'd3; op2 = imm; end
                3'd6: begin ok = 1'b1; alu = 4'd4; op2 = imm; end
                3'd7: begin ok = 1'b1; alu = 4'd5; op2 = imm; end
                3'd1: begin
                    alu = 4'd6;
                    ok  = (xlen == 32) ? (f7 == 7'h00) : (f6 == 6'h00);
                    op2 = (xlen == 32) ? 64'(ins[24:20]) : 64'(ins[25:20]);
                end
                default: begin
                    op2 = (xlen == 32) ? 64'(ins[24:20]) : 64'(ins[25:20]);
                    if (xlen == 32) begin
                        ok  = (f7 == 7'h00) || (f7 == 7'h20);
                        alu = (f7 == 7'h20) ? 4'd8 : 4'd7;
                    end else begin
                        ok  = (f6 == 6'h00) || (f6 == 6'h10);
                        alu = (f6 == 6'h10) ? 4'd8 : 4'd7;
                    end
                end
            endcase
        end else if (opc == 7'h1B && xlen == 64) begin
            word = 1'b1;
            if (f3 == 3'd0) begin
                ok = 1'b1; alu = 4'd0; op2 = imm;
            end else if (f3 == 3'd1) begin
                ok = (f7 == 7'h00); alu = 4'd6; op2 = 64'(ins[24:20]);
            end else if (f3 == 3'd5) begin
                ok  = (f7 == 7'h00) || (f7 == 7'h20);
                alu = (f7 == 7'h20) ? 4'd8 : 4'd7;
                op2 = 64'(ins[24:20]);
            end
        end
        src = regs[rs1];
`ifdef ID_FWD_EN
        if (fwd_we && fwd_waddr == rs1 && rs1 != 5'd0) src = fwd_wdata;
`endif
        e.op1   = ok ? (src & mask) : 64'd0;
        e.op2   = ok ? (op2 & mask) : 64'd0;
        e.alu   = ok ? alu : 4'd0;
        e.word  = ok & word;
        e.we    = ok;
        e.waddr = ok ? ins[11:7] : 5'd0;
        e.ill   = ~ok;
        e.raddr = rs1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head32(input ent_t e);
        chk("op1_32", 64'(op1_32), e.op1);
        chk("op2_32", 64'(op2_32), e.op2);
        chk("alu_32", 64'(alu32), 64'(e.alu));
        chk("word_32", 64'(word32), 64'(e.word));
        chk("we_32", 64'(we32), 64'(e.we));
        chk("waddr_32", 64'(waddr32), 64'(e.waddr));
        chk("ill_32", 64'(ill32), 64'(e.ill));
    endtask

    task automatic chk_head64(input ent_t e);
        chk("op1_64", op1_64, e.op1);
        chk("op2_64", op2_64, e.op2);
        chk("alu_64", 64'(alu64), 64'(e.alu));
        chk("word_64", 64'(word64), 64'(e.word));
        chk("we_64", 64'(we64), 64'(e.we));
        chk("waddr_64", 64'(waddr64), 64'(e.waddr));
        chk("ill_64", 64'(ill64), 64'(e.ill));
    endtask

    task automatic chk_zero;
        ent_t z;
        z = '{op1: 64'd0, op2: 64'd0, alu: 4'd0, word: 1'b0, we: 1'b0, waddr: 5'd0, ill: 1'b0, raddr: 5'd0};
        chk("rst_valid32", 64'(out_valid32), 64'd0);
        chk("rst_valid64", 64'(out_valid64), 64'd0);
        chk_head32(z);
        chk_head64(z);
    endtask

    // One cycle: drive, check combinational and buffered outputs, advance the model at the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                        output logic acc);
        ent_t e32, e64;
        in_valid  = v;
        inst      = ins;
        out_ready = rdy;
        flush     = fl;
        #1;
        e32 = model(32, ins);
        e64 = model(64, ins);
        chk("in_ready32", 64'(in_ready32), 64'(!rst && q32.size() < 2));
        chk("in_ready64", 64'(in_ready64), 64'(!rst && q64.size() < 2));
        chk("out_valid32", 64'(out_valid32), 64'(q32.size() > 0));
        chk("out_valid64", 64'(out_valid64), 64'(q64.size() > 0));
        chk("re32", 64'(re32), 64'(e32.we));
        chk("re64", 64'(re64), 64'(e64.we));
        if (e32.we) chk("raddr32", 64'(raddr32), 64'(e32.raddr));
        if (e64.we) chk("raddr64", 64'(raddr64), 64'(e64.raddr));
        if (q32.size() > 0) chk_head32(q32[0]);
        if (q64.size() > 0) chk_head64(q64[0]);
        acc = v && !rst && !fl && q32.size() < 2;
        @(posedge clk);
        if (rst || fl) begin
            q32.delete();
            q64.delete();
        end else begin
            if (q32.size() > 0 && rdy) begin
                void'(q32.pop_front());
                void'(q64.pop_front());
            end
            if (acc) begin
                q32.push_back(e32);
                q64.push_back(e64);
            end
        end
        @(negedge clk);
    endtask

    logic [31:0] dir_list [10];
    logic [31:0] bp_list [4];

    initial begin
        logic        acc;
        logic [31:0] ins;
        int          idx;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        inst      = 32'd0;
        out_ready = 1'b1;
        fwd_we    = 1'b0;
        fwd_waddr = 5'd0;
        fwd_wdata = 64'd0;
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        @(negedge clk);

        step(1'b1, 32'hFFF08293, 1'b1, 1'b0, acc);
        chk_zero();
        rst = 1'b0;

        regs[1] = 64'd7;
        step(1'b1, 32'hFFF08293, 1'b1, 1'b0, acc);
        chk("addi_op1", 64'(op1_32), 64'd7);
        chk("addi_op2", 64'(op2_32), 64'hFFFF_FFFF);
        chk("addi_alu", 64'(alu32), 64'd0);
        chk("addi_waddr", 64'(waddr32), 64'd5);
        chk("addi_we", 64'(we32), 64'd1);

        dir_list = '{32'hFFF1B113, 32'h41F0D093, 32'h02009093, 32'h02809093, 32'h4030D09B,
                     32'h0000A09B, 32'h00000013, 32'h0000F013, 32'h4000D013, 32'h00000033};
        for (int i = 0; i < 10; i++) begin
            step(1'b1, dir_list[i], 1'b1, 1'b0, acc);
            if (i == 0) begin
                chk("sltiu_op2", 64'(op2_32), 64'hFFFF_FFFF);
                chk("sltiu_alu", 64'(alu32), 64'd2);
            end else if (i == 1) begin
                chk("srai_op2", 64'(op2_32), 64'd31);
                chk("srai_alu", 64'(alu32), 64'd8);
            end else if (i == 2) begin
                chk("shamt5_ill32", 64'(ill32), 64'd1);
                chk("shamt5_we32", 64'(we32), 64'd0);
            end else if (i == 3) begin
                chk("slli40_op2", op2_64, 64'd40);
                chk("slli40_ill", 64'(ill64), 64'd0);
            end else if (i == 4) begin
                chk("sraiw_alu", 64'(alu64), 64'd8);
                chk("sraiw_word", 64'(word64), 64'd1);
            end else if (i == 5) begin
                chk("opimm32_f3_ill", 64'(ill64), 64'd1);
            end
        end

        bp_list = '{32'h00108093, 32'h00210113, 32'h00318193, 32'h00420213};
        idx = 0;
        for (int c = 1; c <= 9; c++) begin
            step(idx < 4, bp_list[idx % 4], !(c >= 2 && c <= 4), 1'b0, acc);
            if (c == 3) chk("bp_ready_c3", 64'(in_ready32), 64'd0);
            if (acc) idx++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd4);

        step(1'b1, 32'h00500293, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00600313, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00700393, 1'b0, 1'b1, acc);
        chk("flush_valid", 64'(out_valid32), 64'd0);
        chk("flush_ready", 64'(in_ready64), 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);

        step(1'b1, 32'h00800413, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00900493, 1'b0, 1'b0, acc);
        rst = 1'b1;
        step(1'b1, 32'h00A00513, 1'b0, 1'b0, acc);
        chk_zero();
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);

        regs[1]   = 64'h11;
        fwd_we    = 1'b1;
        fwd_waddr = 5'd1;
        fwd_wdata = 64'h55;
        step(1'b1, 32'h00008313, 1'b1, 1'b0, acc);
        fwd_we = 1'b0;
`ifdef ID_FWD_EN
        chk("fwd_op1", 64'(op1_32), 64'h55);
`else
        chk("fwd_op1", 64'(op1_32), 64'h11);
`endif
        fwd_we    = 1'b1;
        fwd_waddr = 5'd0;
        step(1'b1, 32'h00500193, 1'b1, 1'b0, acc);
        fwd_we = 1'b0;
        chk("fwd_x0_op1", op1_64, regs[0]);

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0, 1: ins[6:0] = 7'h13;
                2:    ins[6:0] = 7'h1B;
                default: ;
            endcase
            if ((ins[14:12] == 3'd1 || ins[14:12] == 3'd5) && $urandom_range(0, 3) != 0)
                ins[31:26] = ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h00;
            fwd_we    = $urandom_range(0, 1) != 0;
            fwd_waddr = 5'($urandom_range(0, 3));
            fwd_wdata = {$urandom, $urandom};
            step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, acc);
        end
        fwd_we = 1'b0;
        for (int n = 0; n < 3; n++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
